hp_bar_multi: RTL and testbench

- Parametrised successor to the single-player HP tracker/overlay: tracks hit points for NCH tanks.
- Per-channel features: hit-edge detection, saturating damage and heal, frame-counted invulnerability after a hit, bar flashing while invulnerable, and a dead flag.
- Draws one horizontal HP bar per channel over the incoming VGA stream.
- Sits in the video pipeline between the background/tank renderers and the mouse overlay, adding one register stage to timing, rgb and mouse position.

---
 rtl/hp_bar_multi.sv | 180 ++++++++++++++++++
 tb/tb_hp_bar_multi.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_bar_multi.sv
// hp_bar_multi: hit-point tracker for NCH tanks with a per-channel HP bar
// overlay. Sits in the VGA pipeline and adds one register stage to the
// timing, colour and mouse-position signals passing through it.
module hp_bar_multi #(
    parameter int NCH          = 2,
    parameter int HPW          = 8,
    parameter int HP_MAX       = 100,
    parameter int DAMAGE       = 10,
    parameter int HEAL         = 5,
    parameter int INVUL_FRAMES = 16,
    parameter int BAR_X        = 810,
    parameter int BAR_Y0       = 40,
    parameter int BAR_PITCH    = 30,
    parameter int BAR_H        = 16,
    parameter logic [NCH*12-1:0] BAR_RGB   = 24'hF20_3A0,
    parameter logic [11:0]       FLASH_RGB = 12'hFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     hit,
    input  logic [NCH-1:0]     heal,
    input  logic               restore,
    input  logic               select,
    input  logic               hblnk,
    input  logic               vblnk,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    input  logic [11:0]        rgb,
    input  logic [11:0]        xpos_m,
    input  logic [11:0]        ypos_m,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [10:0]        hcount_out,
    output logic [9:0]         vcount_out,
    output logic [11:0]        rgb_out,
    output logic [11:0]        xpos_m_out,
    output logic [11:0]        ypos_m_out,
    output logic [NCH*HPW-1:0] hp_state,
    output logic [NCH-1:0]     dead,
    output logic [NCH-1:0]     hit_ack
);

    logic [HPW-1:0] hp_r      [NCH];
    logic [7:0]     inv_r     [NCH];
    logic [HPW-1:0] hp_nxt_s  [NCH];
    logic [7:0]     inv_nxt_s [NCH];
    logic [NCH-1:0] ack_nxt_s;
    logic [NCH-1:0] hit_r;
    logic [NCH-1:0] heal_r;
    logic [NCH-1:0] hit_ev_s;
    logic [NCH-1:0] heal_ev_s;
    logic [NCH-1:0] dead_r;
    logic [NCH-1:0] hit_ack_r;
    logic           vblnk_r;
    logic           tick_s;
    logic [11:0]    pix_s;

    assign hit_ev_s  = hit & ~hit_r;
    assign heal_ev_s = heal & ~heal_r;
    assign tick_s    = vblnk & ~vblnk_r;
    assign dead      = dead_r;
    assign hit_ack   = hit_ack_r;

    // Bar colour for the current pixel; iterating downwards lets the lowest channel win.
    always_comb begin
        logic [31:0] h_s;
        logic [31:0] v_s;
        logic [31:0] x_hi_s;
        logic [31:0] y_lo_s;
        pix_s  = rgb;
        h_s    = 32'(hcount);
        v_s    = 32'(vcount);
        x_hi_s = 32'd0;
        y_lo_s = 32'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            // Right edge is inclusive, so an empty bar still shows a 1-pixel stub.
            x_hi_s = 32'(BAR_X) + 32'(hp_r[i]);
            y_lo_s = 32'(BAR_Y0 + i * BAR_PITCH);
            pix_s  = (h_s >= 32'(BAR_X) && h_s <= x_hi_s &&
                      v_s >= y_lo_s && v_s < y_lo_s + 32'(BAR_H))
                     ? ((inv_r[i] != 8'd0 && inv_r[i][2]) ? FLASH_RGB : BAR_RGB[12*i +: 12])
                     : pix_s;
        end
    end

    // One-cycle video delay with the overlay colour muxed in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hcount_out <= 11'd0;
            vcount_out <= 10'd0;
            rgb_out    <= 12'd0;
            xpos_m_out <= 12'd0;
            ypos_m_out <= 12'd0;
        end else begin
            hblnk_out  <= hblnk;
            vblnk_out  <= vblnk;
            hsync_out  <= hsync;
            vsync_out  <= vsync;
            hcount_out <= hcount;
            vcount_out <= vcount;
            rgb_out    <= select ? pix_s : rgb;
            xpos_m_out <= xpos_m;
            ypos_m_out <= ypos_m;
        end
    end

    // Per-channel HP / invulnerability update: restore, then hit, then heal.
    always_comb begin
        logic [HPW:0] sum_s;
        sum_s     = {(HPW+1){1'b0}};
        ack_nxt_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            hp_nxt_s[i]  = hp_r[i];
            inv_nxt_s[i] = inv_r[i];
            // One extra bit so the heal sum cannot wrap before clamping.
            sum_s = {1'b0, hp_r[i]} + (HPW+1)'(HEAL);
            if (restore) begin
                hp_nxt_s[i]  = HPW'(HP_MAX);
                inv_nxt_s[i] = 8'd0;
            end else begin
                if (tick_s && inv_r[i] != 8'd0) begin
                    inv_nxt_s[i] = inv_r[i] - 8'd1;
                end else begin
                    inv_nxt_s[i] = inv_r[i];
                end
                if (hit_ev_s[i] && inv_r[i] == 8'd0 && hp_r[i] != {HPW{1'b0}}) begin
                    hp_nxt_s[i]  = (hp_r[i] > HPW'(DAMAGE)) ? (hp_r[i] - HPW'(DAMAGE)) : {HPW{1'b0}};
                    inv_nxt_s[i] = 8'(INVUL_FRAMES);
                    ack_nxt_s[i] = 1'b1;
                end else if (heal_ev_s[i] && hp_r[i] != {HPW{1'b0}}) begin
                    hp_nxt_s[i] = (sum_s > (HPW+1)'(HP_MAX)) ? HPW'(HP_MAX) : sum_s[HPW-1:0];
                end else begin
                    hp_nxt_s[i] = hp_r[i];
                end
            end
        end
    end

    // Channel state, edge-detect history and frame-tick history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                hp_r[i]  <= HPW'(HP_MAX);
                inv_r[i] <= 8'd0;
            end
            hit_r     <= {NCH{1'b0}};
            heal_r    <= {NCH{1'b0}};
            dead_r    <= {NCH{1'b0}};
            hit_ack_r <= {NCH{1'b0}};
            vblnk_r   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hp_r[i]   <= hp_nxt_s[i];
                inv_r[i]  <= inv_nxt_s[i];
                dead_r[i] <= (hp_nxt_s[i] == {HPW{1'b0}});
            end
            hit_r     <= hit;
            heal_r    <= heal;
            hit_ack_r <= ack_nxt_s;
            vblnk_r   <= vblnk;
        end
    end

    // Pack the per-channel HP registers onto the flat status bus.
    always_comb begin
        hp_state = {(NCH*HPW){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            hp_state[HPW*i +: HPW] = hp_r[i];
        end
    end

endmodule

// File: tb/tb_hp_bar_multi.sv
// Self-checking bench for hp_bar_multi: randomized video/event stimulus
// against a rule-level model of HP, invulnerability and bar drawing.
module tb_hp_bar_multi;
    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] hit, heal;
    logic restore, sel, hblnk, vblnk, hsync, vsync;
    logic [10:0] hcount;
    logic [9:0] vcount;
    logic [11:0] rgb, xpos_m, ypos_m;
    logic hblnk_o, vblnk_o, hsync_o, vsync_o;
    logic [10:0] hcount_o;
    logic [9:0] vcount_o;
    logic [11:0] rgb_o, xpos_o, ypos_o;
    logic [15:0] hp_state;
    logic [1:0] dead, hit_ack;

    // second instance: one channel with HP_MAX = 25 for saturation
    logic hit2, heal2;
    logic s_hb, s_vb, s_hs, s_vs;
    logic [10:0] s_hc;
    logic [9:0] s_vc;
    logic [11:0] s_rgb, s_x, s_y;
    logic [7:0] hp2;
    logic dead2, ack2;

    hp_bar_multi dut (
        .clk(clk), .rst(rst), .hit(hit), .heal(heal), .restore(restore), .select(sel),
        .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
        .hcount(hcount), .vcount(vcount), .rgb(rgb), .xpos_m(xpos_m), .ypos_m(ypos_m),
        .hblnk_out(hblnk_o), .vblnk_out(vblnk_o), .hsync_out(hsync_o), .vsync_out(vsync_o),
        .hcount_out(hcount_o), .vcount_out(vcount_o), .rgb_out(rgb_o),
        .xpos_m_out(xpos_o), .ypos_m_out(ypos_o),
        .hp_state(hp_state), .dead(dead), .hit_ack(hit_ack)
    );

    hp_bar_multi #(.NCH(1), .HP_MAX(25), .BAR_RGB(12'h3A0)) dut_sat (
        .clk(clk), .rst(rst), .hit(hit2), .heal(heal2), .restore(restore), .select(sel),
        .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
        .hcount(hcount), .vcount(vcount), .rgb(rgb), .xpos_m(xpos_m), .ypos_m(ypos_m),
        .hblnk_out(s_hb), .vblnk_out(s_vb), .hsync_out(s_hs), .vsync_out(s_vs),
        .hcount_out(s_hc), .vcount_out(s_vc), .rgb_out(s_rgb),
        .xpos_m_out(s_x), .ypos_m_out(s_y),
        .hp_state(hp2), .dead(dead2), .hit_ack(ack2)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int hp_m [2];
    int inv_m [2];
    logic [1:0] ack_m;
    logic [1:0] hit_p, heal_p;
    logic vblnk_p;
    logic [39:0] e_vid;   // {hblnk,vblnk,hsync,vsync,hcount,vcount,xpos,ypos} minus widths below
    logic [11:0] e_rgb;

    function automatic logic [11:0] colour(int i);
        return (i == 0) ? 12'h3A0 : 12'hF20;
    endfunction

    function automatic logic [11:0] pix_model(int h, int v, logic [11:0] c, logic s);
        if (!s) return c;
        for (int i = 0; i < NCH; i++) begin
            if (h >= 810 && h <= 810 + hp_m[i] && v >= 40 + 30 * i && v < 40 + 30 * i + 16)
                return (((inv_m[i] / 4) % 2) == 1) ? 12'hFFF : colour(i);
        end
        return c;
    endfunction

    function automatic logic [15:0] e_hp();
        return {8'(hp_m[1]), 8'(hp_m[0])};
    endfunction

    function automatic logic [1:0] e_dead();
        return {hp_m[1] == 0, hp_m[0] == 0};
    endfunction

    function automatic logic [57:0] act_vid();
        return {hblnk_o, vblnk_o, hsync_o, vsync_o, hcount_o, vcount_o, xpos_o, ypos_o, 9'd0};
    endfunction

    logic [57:0] e_vid_full;

    // advance one clock from a falling edge, updating the model from the applied inputs
    task automatic cyc();
        bit tick, he, le;
        int ninv;
        rgb = 12'($urandom); xpos_m = 12'($urandom); ypos_m = 12'($urandom);
        hsync = 1'($urandom); vsync = 1'($urandom); hblnk = 1'($urandom);
        if (!rst) begin
            e_vid_full = 58'd0; e_rgb = 12'd0;
            for (int i = 0; i < NCH; i++) begin hp_m[i] = 100; inv_m[i] = 0; end
            ack_m = 2'b00; hit_p = 2'b00; heal_p = 2'b00; vblnk_p = 1'b0;
        end else begin
            e_vid_full = {hblnk, vblnk, hsync, vsync, hcount, vcount, xpos_m, ypos_m, 9'd0};
            e_rgb = pix_model(int'(hcount), int'(vcount), rgb, sel);
            tick = vblnk && !vblnk_p;
            for (int i = 0; i < NCH; i++) begin
                he = hit[i] && !hit_p[i];
                le = heal[i] && !heal_p[i];
                ack_m[i] = 1'b0;
                if (restore) begin
                    hp_m[i] = 100; inv_m[i] = 0;
                end else begin
                    ninv = (tick && inv_m[i] > 0) ? inv_m[i] - 1 : inv_m[i];
                    if (he && inv_m[i] == 0 && hp_m[i] > 0) begin
                        hp_m[i] = (hp_m[i] > 10) ? hp_m[i] - 10 : 0;
                        ninv = 16; ack_m[i] = 1'b1;
                    end else if (le && hp_m[i] > 0) begin
                        hp_m[i] = (hp_m[i] + 5 > 100) ? 100 : hp_m[i] + 5;
                    end
                    inv_m[i] = ninv;
                end
            end
            hit_p = hit; heal_p = heal; vblnk_p = vblnk;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame_tick();
        vblnk = 1'b1; cyc();
        vblnk = 1'b0; cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0; hit = 2'b00; heal = 2'b00; restore = 1'b0; sel = 1'b1; vblnk = 1'b0;
        hit2 = 1'b0; heal2 = 1'b0; hcount = 11'd820; vcount = 10'd45;
        @(negedge clk);
        cyc(); cyc();
        checks++;
        if ({act_vid(), rgb_o} !== 70'd0) begin
            errors++; $display("FAIL reset_video: got %h want 0", {act_vid(), rgb_o});
        end
        checks++;
        if (hp_state !== 16'h6464 || dead !== 2'b00 || hit_ack !== 2'b00) begin
            errors++; $display("FAIL reset_hp: got hp=%h dead=%b ack=%b want 6464/00/00", hp_state, dead, hit_ack);
        end
        checks++;
        if (hp2 !== 8'd25 || dead2 !== 1'b0) begin
            errors++; $display("FAIL reset_hp2: got %0d want 25", hp2);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_bar_draw();
        int rows [7] = '{40, 55, 56, 39, 70, 85, 86};
        logic [11:0] exp;
        int ch;
        sel = 1'b1;
        foreach (rows[r]) begin
            ch = (rows[r] >= 40 && rows[r] < 56) ? 0 : (rows[r] >= 70 && rows[r] < 86) ? 1 : -1;
            for (int h = 805; h <= 915; h++) begin
                hcount = 11'(h); vcount = 10'(rows[r]);
                cyc();
                exp = (ch >= 0 && h >= 810 && h <= 910) ? colour(ch) : rgb;
                checks++;
                if (rgb_o !== exp) begin
                    errors++; $display("FAIL bar_draw h=%0d v=%0d: got %h want %h", h, rows[r], rgb_o, exp);
                end
            end
        end
        checks++;
        if (hp_state !== 16'h6464) begin
            errors++; $display("FAIL bar_hp: got %h want 6464", hp_state);
        end
    endtask

    task automatic test_hit();
        int acks = 0;
        hit[0] = 1'b1; cyc();
        checks++;
        if (hp_state[7:0] !== 8'd90 || hit_ack !== 2'b01) begin
            errors++; $display("FAIL hit_first: got hp=%0d ack=%b want 90/01", hp_state[7:0], hit_ack);
        end
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (hit_ack != 2'b00) acks++;
        end
        checks++;
        if (acks != 0 || hp_state[7:0] !== 8'd90) begin
            errors++; $display("FAIL hit_hold: got acks=%0d hp=%0d want 0/90", acks, hp_state[7:0]);
        end
        hit[0] = 1'b0;
        repeat (8) frame_tick();
        hit[0] = 1'b1; cyc();
        checks++;
        if (hp_state[7:0] !== 8'd90 || hit_ack !== 2'b00) begin
            errors++; $display("FAIL hit_invul: got hp=%0d ack=%b want 90/00", hp_state[7:0], hit_ack);
        end
        hit[0] = 1'b0;
        repeat (8) frame_tick();
        hit[0] = 1'b1; cyc();
        checks++;
        if (hp_state[7:0] !== 8'd80 || hit_ack !== 2'b01 || hp_state !== e_hp()) begin
            errors++; $display("FAIL hit_after: got hp=%h ack=%b want %h/01", hp_state, hit_ack, e_hp());
        end
        hit[0] = 1'b0; cyc();
        checks++;
        if (hit_ack !== 2'b00) begin
            errors++; $display("FAIL hit_ack_pulse: got %b want 00", hit_ack);
        end
    endtask

    task automatic test_invul_flash();
        logic [11:0] exp;
        sel = 1'b1; hcount = 11'd815; vcount = 10'd75;
        hit[1] = 1'b1; cyc();
        hit[1] = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            cyc();
            exp = ((((16 - k) / 4) % 2) == 1) ? 12'hFFF : 12'hF20;
            checks++;
            if (rgb_o !== exp) begin
                errors++; $display("FAIL flash tick=%0d: got %h want %h", k, rgb_o, exp);
            end
            if (k < 16) frame_tick();
        end
    endtask

    task automatic test_saturation();
        int h2 = 25;
        int exp;
        for (int n = 0; n < 5; n++) begin
            hit2 = 1'b1; cyc();
            exp = (h2 > 10) ? h2 - 10 : 0;
            checks++;
            if (hp2 !== 8'(exp) || ack2 !== 1'(h2 > 0) || dead2 !== 1'(exp == 0)) begin
                errors++; $display("FAIL sat hit%0d: got hp=%0d ack=%b dead=%b want %0d", n, hp2, ack2, dead2, exp);
            end
            h2 = exp;
            hit2 = 1'b0;
            repeat (16) frame_tick();
        end
        heal2 = 1'b1; cyc();
        checks++;
        if (hp2 !== 8'd0 || dead2 !== 1'b1) begin
            errors++; $display("FAIL sat_heal: got hp=%0d dead=%b want 0/1", hp2, dead2);
        end
        heal2 = 1'b0; cyc();
    endtask

    task automatic test_heal();
        int want [3] = '{95, 100, 100};
        for (int n = 0; n < 3; n++) begin
            heal[1] = 1'b1; cyc();
            checks++;
            if (hp_state[15:8] !== 8'(want[n]) || hp_state !== e_hp()) begin
                errors++; $display("FAIL heal%0d: got %0d want %0d", n, hp_state[15:8], want[n]);
            end
            heal[1] = 1'b0; cyc();
        end
        hit[0] = 1'b1; heal[0] = 1'b1; cyc();
        checks++;
        if (hp_state[7:0] !== 8'd70 || hit_ack !== 2'b01) begin
            errors++; $display("FAIL hit_heal_same: got hp=%0d ack=%b want 70/01", hp_state[7:0], hit_ack);
        end
        hit = 2'b00; heal = 2'b00; cyc();
    endtask

    task automatic test_restore();
        restore = 1'b1; hit[1] = 1'b1; cyc();
        restore = 1'b0; hit[1] = 1'b0;
        checks++;
        if (hp_state !== 16'h6464 || hit_ack !== 2'b00 || dead !== 2'b00 || hp2 !== 8'd25 || dead2 !== 1'b0) begin
            errors++; $display("FAIL restore: got hp=%h ack=%b hp2=%0d want 6464/00/25", hp_state, hit_ack, hp2);
        end
        hit[0] = 1'b1; cyc();
        checks++;
        if (hp_state[7:0] !== 8'd90 || hit_ack !== 2'b01) begin
            errors++; $display("FAIL restore_inv_clear: got hp=%0d ack=%b want 90/01", hp_state[7:0], hit_ack);
        end
        hit[0] = 1'b0; cyc();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            hit = 2'($urandom_range(0, 3)); heal = 2'($urandom_range(0, 3));
            restore = ($urandom_range(0, 60) == 0);
            vblnk = ($urandom_range(0, 2) == 0);
            sel = 1'($urandom);
            hcount = 11'($urandom_range(800, 920));
            vcount = 10'($urandom_range(35, 95));
            cyc();
            checks++;
            if (hp_state !== e_hp() || dead !== e_dead() || hit_ack !== ack_m) begin
                errors++; $display("FAIL rand_state k=%0d: got %h/%b/%b want %h/%b/%b", k, hp_state, dead, hit_ack, e_hp(), e_dead(), ack_m);
            end
            checks++;
            if (rgb_o !== e_rgb || act_vid() !== e_vid_full) begin
                errors++; $display("FAIL rand_video k=%0d: got %h/%h want %h/%h", k, rgb_o, act_vid(), e_rgb, e_vid_full);
            end
        end
        hit = 2'b00; heal = 2'b00; restore = 1'b0; vblnk = 1'b0; cyc();
    endtask

    task automatic test_async_reset();
        sel = 1'b0; hsync = 1'b1; hcount = 11'd500; vcount = 10'd300;
        hit[0] = 1'b1; cyc();
        hit[0] = 1'b0; cyc();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({act_vid(), rgb_o} !== 70'd0 || hp_state !== 16'h6464 || dead !== 2'b00 || hit_ack !== 2'b00) begin
            errors++; $display("FAIL async_reset: got vid=%h hp=%h want 0/6464", {act_vid(), rgb_o}, hp_state);
        end
        @(negedge clk);
        cyc();
        rst = 1'b1;
        hcount = 11'd123; cyc();
        checks++;
        if (hcount_o !== 11'd123 || hp_state !== e_hp() || rgb_o !== e_rgb) begin
            errors++; $display("FAIL after_reset: got hc=%0d hp=%h want 123/%h", hcount_o, hp_state, e_hp());
        end
    endtask

    initial begin
        test_reset();
        test_bar_draw();
        test_hit();
        test_invul_flash();
        test_saturation();
        test_heal();
        test_restore();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
